// File: rtl/div_ctrl.sv
// Sequencing controller between the EX stage and a 32-cycle iterative divider.
// Launches DIV/DIVU, holds the front-end, captures HI/LO and drains cancelled runs.
module div_ctrl #(
  parameter int ZERO_BYPASS = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        req_signed,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  input  logic        flush,
  input  logic        pipe_stall,
  output logic        stall_o,
  output logic        hilo_we,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_valid,
  output logic        div_sign,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic        div_busy,
  input  logic [63:0] div_result
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_DONE   = 3'd3,
    S_DRAIN  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] div_a_q, div_a_d;
  logic [31:0] div_b_q, div_b_d;
  logic        div_sign_q, div_sign_d;
  logic        zero_div;

  assign zero_div = (ZERO_BYPASS != 0) && (opb == 32'd0);

  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_a_d    = div_a_q;
    div_b_d    = div_b_q;
    div_sign_d = div_sign_q;
    case (state_q)
      S_IDLE: begin
        if (!flush && req) begin
          if (zero_div) begin
            state_d = S_DONE;
            hi_d    = opa;
            lo_d    = 32'hFFFF_FFFF;
          end else begin
            state_d    = S_LAUNCH;
            div_a_d    = opa;
            div_b_d    = opb;
            div_sign_d = req_signed;
          end
        end
      end
      S_LAUNCH: state_d = flush ? S_DRAIN : S_WAIT;
      S_WAIT: begin
        if (flush) begin
          state_d = S_DRAIN;
        end else if (!div_busy) begin
          state_d = S_DONE;
          hi_d    = div_result[63:32];
          lo_d    = div_result[31:0];
        end
      end
      S_DONE: begin
        if (flush || !pipe_stall) state_d = S_IDLE;
      end
      // The divider cannot be aborted, so a cancelled run is waited out and discarded.
      S_DRAIN: begin
        if (!div_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      div_a_q    <= 32'd0;
      div_b_q    <= 32'd0;
      div_sign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_a_q    <= div_a_d;
      div_b_q    <= div_b_d;
      div_sign_q <= div_sign_d;
    end
  end

  // stall_o looks at req in IDLE, so it is gated by rst_n to read 0 while reset is held.
  assign stall_o   = rst_n & (((state_q == S_IDLE) & req & ~flush) |
                              (state_q == S_LAUNCH) | (state_q == S_WAIT) |
                              ((state_q == S_DRAIN) & req));
  assign hilo_we   = (state_q == S_DONE) & ~flush & ~pipe_stall;
  assign div_valid = (state_q == S_LAUNCH);
  assign div_sign  = div_sign_q;
  assign div_a     = div_a_q;
  assign div_b     = div_b_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 Parameter ZERO_BYPASS, default 1, 1 = zero divisor handled locally without starting the divider; 0 = zero divisor sent to divider like any other.
REQ-002 clk  in  1  sole clock, all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 req  in  1  EX stage holds a DIV/DIVU instruction.
REQ-005 req_signed  in  1  1 = DIV, 0 = DIVU.
REQ-006 opa  in  32  dividend.
REQ-007 opb  in  32  divisor.
REQ-008 flush  in  1  exception/cancel of the EX instruction.
REQ-009 pipe_stall  in  1  downstream stall; the instruction cannot retire this cycle.
REQ-010 stall_o  out  1  freeze the pipeline front-end.
REQ-011 hilo_we  out  1  one-cycle HI/LO write strobe.
REQ-012 hi  out  32  remainder, registered.
REQ-013 lo  out  32  quotient, registered.
REQ-014 div_valid  out  1  start pulse to the divider.
REQ-015 div_sign  out  1  signed-mode bit to the divider.
REQ-016 div_a  out  32  latched dividend to the divider.
REQ-017 div_b  out  32  latched divisor to the divider.
REQ-018 div_busy  in  1  divider stall; high for 32 cycles starting the cycle after div_valid.
REQ-019 div_result  in  64  {remainder, quotient}; valid when div_busy is low after a run.

Function
REQ-020 FSM states: IDLE, LAUNCH, WAIT, DONE, DRAIN; the FSM is a registered state machine.
REQ-021 IDLE transitions, with flush taking priority over req:
- flush -> stay in IDLE, no action.
- req, and (opb==0 with ZERO_BYPASS=1) -> DONE, with hi<=opa and lo<=32'hFFFFFFFF.
- req otherwise -> LAUNCH, with opa, opb and req_signed latched into div_a, div_b and div_sign.
REQ-022 LAUNCH: div_valid=1 for exactly this cycle; next state is WAIT, or DRAIN if flush.
REQ-023 WAIT transitions:
- flush -> DRAIN.
- div_busy=0 -> DONE, with hi<=div_result[63:32] and lo<=div_result[31:0].
- otherwise stay in WAIT.
REQ-024 DONE transitions:
- flush -> IDLE with no write.
- pipe_stall=0 -> hilo_we=1 this cycle, then IDLE.
- pipe_stall=1 -> stay in DONE with hilo_we=0.
REQ-025 DRAIN: the divider is not abortable; remain in DRAIN until div_busy=0, then go to IDLE; the result is discarded and hi/lo are unchanged.
REQ-026 stall_o = (IDLE & req & ~flush) | LAUNCH | WAIT | (DRAIN & req); stall_o is 0 in DONE.
REQ-027 hilo_we is asserted only in DONE, never twice for one request.
REQ-028 div_valid is never asserted outside LAUNCH; at most one divider run is outstanding at a time.
REQ-029 div_a, div_b and div_sign hold stable from LAUNCH until the next IDLE->LAUNCH transition.
REQ-030 Latency with a nonzero divisor and no stalls: req first seen in cycle 0, LAUNCH in cycle 1, WAIT in cycles 2-34, capture in cycle 34, hilo_we in cycle 35.
REQ-031 Latency with a zero divisor and bypass: hilo_we in cycle 1.
REQ-032 A req present in DRAIN is not started until the FSM returns to IDLE; it launches on the following cycle.
REQ-033 hi/lo change only on a capture (WAIT->DONE) or a bypass (IDLE->DONE).

Reset
REQ-034 rst_n low asynchronously forces the following values:
- state = IDLE.
- stall_o = hilo_we = div_valid = 0.
- hi = lo = 0.
- div_a = div_b = 0, div_sign = 0.
REQ-035 Reset mid-operation abandons any run with no HI/LO write; the divider is reset by the same reset net.
REQ-036 The first request after reset is deasserted is accepted normally in IDLE.

Verification
REQ-037 DIVU: opa=100, opb=7, no stalls -> stall_o high cycles 0-34; hilo_we in cycle 35 with hi=2, lo=14.
REQ-038 DIV: opa=-7 (0xFFFFFFF9), opb=2 -> hi=0xFFFFFFFF (-1), lo=0xFFFFFFFD (-3); div_sign=1 throughout the run.
REQ-039 Zero divisor: opa=0x1234, opb=0, ZERO_BYPASS=1 -> div_valid never asserted; hilo_we in cycle 1 with hi=0x1234, lo=0xFFFFFFFF.
REQ-040 Flush in cycle 10 of a run -> DRAIN until div_busy falls; no hilo_we; hi/lo unchanged; a new req in cycle 12 launches the cycle after IDLE is reached.
REQ-041 pipe_stall held high for 3 cycles on entry to DONE -> stall_o low; hilo_we delayed to the first cycle with pipe_stall low; exactly one strobe.
REQ-042 rst_n pulsed low in WAIT -> all outputs reach reset values immediately; no hilo_we; the next req completes with the correct result.
